// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte sequencer.
//   seq_state_t   : sequencer FSM states
//   START_Q       : quarters in the START condition
//   BIT_Q         : quarters per SCL bit period
//   STOP_Q        : quarters in the STOP condition
//   BITS_PER_BYTE : bits per ADDR/DATA frame (8 data bits + ACK)
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StData,
        StStop,
        StDone
    } seq_state_t;

    localparam int unsigned START_Q       = 2;
    localparam int unsigned BIT_Q         = 4;
    localparam int unsigned STOP_Q        = 4;
    localparam int unsigned BITS_PER_BYTE = 9;

    // True when quarter q is the final quarter of the given state.
    function automatic logic last_quarter(input seq_state_t st, input logic [1:0] q);
        unique case (st)
            StStart:        last_quarter = (q == 2'(START_Q - 1));
            StAddr, StData: last_quarter = (q == 2'(BIT_Q - 1));
            StStop:         last_quarter = (q == 2'(STOP_Q - 1));
            default:        last_quarter = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator for the I2C sequencer.
//   CLK  : system clock
//   rst  : asynchronous active-high reset
//   clr  : hold counter at 0 and suppress ticks (sequencer idle)
//   hold : hold counter at 0 and suppress ticks (SCL stretched by target)
//   tick : one-cycle pulse every QDIV cycles while neither clr nor hold
module i2c_qtick_gen #(
    parameter int unsigned QDIV = 390
) (
    input  logic CLK,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CntW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(QDIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || hold || (cnt_q == CntLast)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = !clr && !hold && (cnt_q == CntLast);

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Single-master I2C transaction sequencer: START, address+R/W, ACK, one data
// byte, ACK/NACK, STOP. SCL and SDA are driven as open-drain tristate enables
// (1 = released, 0 = drive low).
//   CLK, rst        : system clock, asynchronous active-high reset
//   req, rw, addr,  : request (sampled only while idle), direction,
//   wdata           :   7-bit target address, write byte
//   busy, done      : transaction in progress, one-cycle completion pulse
//   rdata, ack_err  : read byte, NACK status (held until next accept)
//   scl_t, sda_t    : tristate enables for SCL and SDA
//   sda_i, scl_i    : pad inputs
// Build option: define I2C_CLK_STRETCH_EN to honour target clock stretching
// (quarter counter held while SCL is observed low during bit quarter 2).
module i2c_byte_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned QDIV = 390
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_err,
    output logic       scl_t,
    output logic       sda_t,
    input  logic       sda_i,
    input  logic       scl_i
);

    localparam logic [3:0] AckBit = 4'(BITS_PER_BYTE - 1);

    seq_state_t state_q;
    logic [1:0] q_q;
    logic [3:0] bit_q;
    logic [7:0] sr_q;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       tick;
    logic       hold;

`ifdef I2C_CLK_STRETCH_EN
    // q2 only starts counting once the target has actually let SCL go high.
    assign hold = ((state_q == StAddr) || (state_q == StData)) && (q_q == 2'd2) && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold = 1'b0;
`endif

    i2c_qtick_gen #(
        .QDIV (QDIV)
    ) u_qtick (
        .CLK  (CLK),
        .rst  (rst),
        .clr  (state_q == StIdle),
        .hold (hold),
        .tick (tick)
    );

    // Every output is registered; on a tick the levels for the quarter being
    // entered are loaded, so they appear the cycle after the tick.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= 2'd0;
            bit_q   <= 4'd0;
            sr_q    <= 8'd0;
            wdata_q <= 8'd0;
            rw_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'd0;
            ack_err <= 1'b0;
            scl_t   <= 1'b1;
            sda_t   <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    scl_t <= 1'b1;
                    sda_t <= 1'b1;
                    if (req) begin
                        state_q <= StStart;
                        q_q     <= 2'd0;
                        bit_q   <= 4'd0;
                        sr_q    <= {addr, rw};
                        wdata_q <= wdata;
                        rw_q    <= rw;
                        busy    <= 1'b1;
                        rdata   <= 8'd0;
                        ack_err <= 1'b0;
                    end
                end

                StStart: begin
                    if (tick) begin
                        if (last_quarter(state_q, q_q)) begin
                            state_q <= StAddr;
                            q_q     <= 2'd0;
                            bit_q   <= 4'd0;
                            scl_t   <= 1'b0;
                            sda_t   <= sr_q[7];
                        end else begin
                            q_q   <= q_q + 2'd1;
                            sda_t <= 1'b0;
                        end
                    end
                end

                StAddr, StData: begin
                    if (tick) begin
                        unique case (q_q)
                            2'd0: q_q <= 2'd1;
                            2'd1: begin
                                q_q   <= 2'd2;
                                scl_t <= 1'b1;
                            end
                            2'd2: begin
                                q_q <= 2'd3;
                                if (bit_q == AckBit) begin
                                    // Read ACK slot is our own NACK, not a status.
                                    if ((state_q == StAddr || !rw_q) && sda_i) begin
                                        ack_err <= 1'b1;
                                    end
                                end else if (state_q == StData && rw_q) begin
                                    rdata <= {rdata[6:0], sda_i};
                                end
                            end
                            default: begin
                                q_q   <= 2'd0;
                                scl_t <= 1'b0;
                                if (bit_q != AckBit) begin
                                    bit_q <= bit_q + 4'd1;
                                    sr_q  <= {sr_q[6:0], 1'b0};
                                    if (bit_q == AckBit - 4'd1) begin
                                        sda_t <= 1'b1;
                                    end else begin
                                        sda_t <= (state_q == StData && rw_q) ? 1'b1 : sr_q[6];
                                    end
                                end else if (state_q == StAddr && !ack_err) begin
                                    state_q <= StData;
                                    bit_q   <= 4'd0;
                                    sr_q    <= wdata_q;
                                    sda_t   <= rw_q ? 1'b1 : wdata_q[7];
                                end else begin
                                    state_q <= StStop;
                                    sda_t   <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                StStop: begin
                    if (tick) begin
                        if (last_quarter(state_q, q_q)) begin
                            state_q <= StDone;
                        end else begin
                            q_q <= q_q + 2'd1;
                            unique case (q_q)
                                2'd0:    scl_t <= 1'b1;
                                default: sda_t <= 1'b1;
                            endcase
                        end
                    end
                end

                StDone: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
module tb_i2c_byte_sequencer;

    localparam int unsigned QDIV = 4;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ack_err, scl_t, sda_t;
    logic [7:0] rdata;
    logic       sda_line, scl_line;

    // Open-drain bus model: the target and the stretcher only ever pull low.
    logic tgt_low = 1'b0;
    logic stretch_low = 1'b0;
    logic stretch_arm = 1'b0;
    assign sda_line = sda_t & ~tgt_low;
    assign scl_line = scl_t & ~stretch_low;

    i2c_byte_sequencer #(
        .QDIV (QDIV)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .req     (req),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .ack_err (ack_err),
        .scl_t   (scl_t),
        .sda_t   (sda_t),
        .sda_i   (sda_line),
        .scl_i   (scl_line)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Target model: reacts on SCL falling edges, records SDA on rising edges.
    logic       cur_rw = 1'b0;
    logic       cur_ack_addr = 1'b1;
    logic       cur_ack_data = 1'b1;
    logic [7:0] cur_rd = 8'd0;
    int         fall_cnt = 0;
    int         rise_cnt = 0;
    logic       bits [0:31];

    always @(negedge scl_line) begin
        if (fall_cnt == 0 && stretch_arm) stretch_low = 1'b1;
        if (fall_cnt == 8) tgt_low = cur_ack_addr;
        else if (fall_cnt == 17) tgt_low = cur_ack_addr && cur_ack_data && !cur_rw;
        else if (fall_cnt >= 9 && fall_cnt <= 16)
            tgt_low = cur_ack_addr && cur_rw && !cur_rd[16-fall_cnt];
        else tgt_low = 1'b0;
        fall_cnt++;
    end

    always @(posedge scl_line) begin
        if (rise_cnt < 32) bits[rise_cnt] = sda_line;
        rise_cnt++;
    end

    // SCL held low by the bench for 20 cycles after the master releases it.
    always @(posedge scl_t) begin
        if (stretch_arm && stretch_low) begin
            stretch_arm = 1'b0;
            repeat (20) @(posedge CLK);
            #1 stretch_low = 1'b0;
        end
    end

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rd;
        int         lat;
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic [7:0] rdata;
        logic       err;
        int         rises;
    } vec_t;

    vec_t vecs [6];

    task automatic arm_target(input vec_t v);
        cur_rw = v.rw;
        cur_ack_addr = v.ack_addr;
        cur_ack_data = v.ack_data;
        cur_rd = v.rd;
        fall_cnt = 0;
        rise_cnt = 0;
        tgt_low = 1'b0;
        for (int i = 0; i < 32; i++) bits[i] = 1'b1;
    endtask

    // Counts edges from the accept edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            #1 lat++;
        end while (!done && lat < 2000);
    endtask

    task automatic run_txn(input vec_t v, output int lat);
        arm_target(v);
        @(posedge CLK);
        #1;
        rw = v.rw;
        addr = v.addr;
        wdata = v.wdata;
        req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        check("busy_after_accept", busy, 1);
        wait_done(lat);
    endtask

    task automatic check_txn(input string tag, input vec_t v, input int lat);
        logic [7:0] ab;
        logic [7:0] db;
        ab = 8'd0;
        db = 8'd0;
        for (int i = 0; i < 8; i++) begin
            ab = {ab[6:0], bits[i]};
            db = {db[6:0], bits[9+i]};
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_scl_rises"}, rise_cnt, v.rises);
        check({tag, "_addr_byte"}, ab, v.abyte);
        check({tag, "_addr_ack_line"}, bits[8], !v.ack_addr);
        if (v.rises == 19) begin
            check({tag, "_data_byte"}, db, v.dbyte);
            check({tag, "_data_ack_line"}, bits[17], v.rw ? 1'b1 : !v.ack_data);
        end
        check({tag, "_rdata"}, rdata, v.rdata);
        check({tag, "_ack_err"}, ack_err, v.err);
        check({tag, "_bus_idle"}, {scl_t, sda_t}, 2'b11);
    endtask

    initial begin
        int lat;
        int n;
        logic busy_dropped;

        //           rw  addr   wdata  aa  ad  rd     lat  abyte  dbyte  rdata err rises
        vecs[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 313, 8'hA0, 8'hA5, 8'h00, 1'b0, 19};
        vecs[1] = '{1'b1, 7'h50, 8'h00, 1'b1, 1'b0, 8'h3C, 313, 8'hA1, 8'h3C, 8'h3C, 1'b0, 19};
        vecs[2] = '{1'b0, 7'h50, 8'hA5, 1'b0, 1'b1, 8'h00, 169, 8'hA0, 8'h00, 8'h00, 1'b1, 10};
        vecs[3] = '{1'b0, 7'h2A, 8'h0F, 1'b1, 1'b0, 8'h00, 313, 8'h54, 8'h0F, 8'h00, 1'b1, 19};
        vecs[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b0, 8'h81, 313, 8'hFF, 8'h81, 8'h81, 1'b0, 19};
        vecs[5] = '{1'b1, 7'h11, 8'h00, 1'b0, 1'b0, 8'hFF, 169, 8'h23, 8'h00, 8'h00, 1'b1, 10};

        #12;
        check("reset_scl_t", scl_t, 1);
        check("reset_sda_t", sda_t, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rdata", rdata, 0);
        check("reset_ack_err", ack_err, 0);
        @(negedge CLK);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_txn(vecs[k], lat);
            check_txn($sformatf("vec%0d", k), vecs[k], lat);
        end

        // req held high: one transaction, next accept right after the done cycle.
        arm_target(vecs[0]);
        @(posedge CLK);
        #1;
        rw = 1'b0;
        addr = 7'h50;
        wdata = 8'hA5;
        req = 1'b1;
        @(posedge CLK);
        #1;
        busy_dropped = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK);
            #1 lat++;
            if (!busy && !done) busy_dropped = 1'b1;
        end while (!done && lat < 2000);
        check("hold_req_latency", lat, 313);
        check("hold_req_busy_steady", busy_dropped, 0);
        check("hold_req_rises", rise_cnt, 19);
        @(posedge CLK);
        #1;
        check("hold_req_reaccept_busy", busy, 1);
        check("hold_req_done_cleared", done, 0);
        req = 1'b0;
        arm_target(vecs[0]);
        wait_done(lat);
        check_txn("hold_req_second", vecs[0], lat);

        // Asynchronous reset during DATA bit 3 of a read.
        arm_target(vecs[4]);
        cur_rd = 8'hFF;
        @(posedge CLK);
        #1;
        rw = 1'b1;
        addr = 7'h7F;
        req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        n = 0;
        while (fall_cnt < 13 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        check("rst_reached_data_bit3", fall_cnt >= 13, 1);
        #2;
        check("rst_pre_rdata", rdata, 8'h07);
        rst = 1'b1;
        tgt_low = 1'b0;
        #1;
        check("rst_mid_scl_t", scl_t, 1);
        check("rst_mid_sda_t", sda_t, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rdata", rdata, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        run_txn(vecs[0], lat);
        check_txn("after_rst", vecs[0], lat);

`ifdef I2C_CLK_STRETCH_EN
        stretch_arm = 1'b1;
        run_txn(vecs[0], lat);
        check("stretch_latency", lat, 333);
        check_txn("stretch", '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 333, 8'hA0, 8'hA5,
                               8'h00, 1'b0, 19}, lat);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
